// File: rtl/arm_dp_pkg.sv
// arm_dp_pkg: shared states, opcodes, condition codes and rotate helper for the ARM data-processing sequencer
package arm_dp_pkg;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'ha, OP_CMN = 4'hb,
                         OP_ORR = 4'hc, OP_MOV = 4'hd, OP_BIC = 4'he, OP_MVN = 4'hf;
  localparam logic [4:0] ALU_BYPASS_B = 5'b10000;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
                         COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;
  localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  function automatic logic [31:0] rot_imm(input logic [11:0] f);
    logic [63:0] d;
    d = {24'b0, f[7:0], 24'b0, f[7:0]} >> {f[11:8], 1'b0};
    return d[31:0];
  endfunction
endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check: evaluates an ARM condition field against NZCV
module arm_cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_dp_sequencer.sv
// arm_dp_sequencer: four-cycle ARM data-processing instruction sequencer driving register file and ALU
module arm_dp_sequencer
  import arm_dp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [RADDR_W-1:0] rf_raddr_a,
  output logic [RADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [4:0]         alu_op,
  output logic               alu_s,
  output logic               alu_out_en,
  output logic [3:0]         alu_flags_in,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [3:0]         alu_flags,
  output logic [3:0]         flags,
  output logic               retired,
  output logic               illegal
);
  state_t state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0] flags_q, flags_d, aflags_q, aflags_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [RADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic pass, bad, test_op, s_bit;
  logic [3:0] opc;
  arm_cond_check u_cond (.cond(instr_q[31:28]), .nzcv(flags_q), .pass(pass));
  assign opc = instr_q[24:21];
  assign test_op = opc[3:2] == 2'b10;
  assign s_bit = instr_q[20] || test_op;
  assign bad = instr_q[27:26] != 2'b00 || (!instr_q[25] && instr_q[4]);
  assign flags = flags_q;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    flags_d = flags_q;
    aflags_d = aflags_q;
    res_d = res_q;
    ra_d = ra_q;
    rb_d = rb_q;
    instr_ready = 1'b0;
    rf_raddr_a = ra_q;
    rf_raddr_b = rb_q;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    alu_a = '0;
    alu_b = '0;
    alu_op = '0;
    alu_s = 1'b0;
    alu_out_en = 1'b0;
    alu_flags_in = '0;
    retired = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        instr_d = instr_valid ? instr : instr_q;
        state_d = instr_valid ? READ : IDLE;
      end
      READ: begin
        ra_d = RADDR_W'(instr_q[19:16]);
        rb_d = RADDR_W'(instr_q[3:0]);
        rf_raddr_a = ra_d;
        rf_raddr_b = rb_d;
        retired = !pass;
        illegal = pass && bad;
        state_d = (!pass || bad) ? IDLE : EXEC;
      end
      EXEC: begin
        alu_a = rf_rdata_a;
        alu_b = instr_q[25] ? DATA_W'(rot_imm(instr_q[11:0])) : rf_rdata_b;
        alu_op = opc == OP_MOV ? ALU_BYPASS_B : {1'b0, opc};
        alu_s = s_bit;
        alu_out_en = 1'b1;
        alu_flags_in = flags_q;
        res_d = alu_result;
        aflags_d = alu_flags;
        state_d = WB;
      end
      WB: begin
        rf_we = !test_op;
        rf_waddr = test_op ? '0 : RADDR_W'(instr_q[15:12]);
        rf_wdata = test_op ? '0 : res_q;
        flags_d = s_bit ? aflags_q : flags_q;
        retired = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      flags_q <= '0;
      aflags_q <= '0;
      res_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
      aflags_q <= aflags_d;
      res_q <= res_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end
endmodule

// File: tb/tb_arm_dp_sequencer.sv
// tb_arm_dp_sequencer: table-driven check of the ARM data-processing sequencer against hand-computed vectors
module tb_arm_dp_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic instr_ready, rf_we, alu_s, alu_out_en, retired, illegal;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr, alu_flags_in, flags;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_a, alu_b, alu_result;
  logic [4:0] alu_op;
  logic [3:0] alu_flags;
  logic [31:0] rf [16];
  logic [31:0] res;
  logic [3:0] fl;
  logic cy;
  logic we_seen = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arm_dp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_s(alu_s), .alu_out_en(alu_out_en), .alu_flags_in(alu_flags_in),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags), .retired(retired), .illegal(illegal)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= (i == 1) ? 32'd5 : 32'd0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
    if (rf_we) we_seen <= 1'b1;
  end

  always_comb begin
    res = alu_a & alu_b;
    fl = alu_flags_in;
    cy = 1'b0;
    case (alu_op)
      5'b00100: begin
        {cy, res} = {1'b0, alu_a} + {1'b0, alu_b};
        fl[1] = cy;
        fl[0] = (alu_a[31] == alu_b[31]) && (res[31] != alu_a[31]);
      end
      5'b00010, 5'b01010: begin
        res = alu_a - alu_b;
        fl[1] = alu_a >= alu_b;
        fl[0] = (alu_a[31] != alu_b[31]) && (res[31] != alu_a[31]);
      end
      5'b10000: res = alu_b;
      default: res = alu_a & alu_b;
    endcase
    fl[3] = res[31];
    fl[2] = res == 32'd0;
  end
  assign alu_result = alu_out_en ? res : 32'd0;
  assign alu_flags = alu_out_en ? fl : 4'd0;

  typedef struct {
    logic [31:0] ins;
    logic skip, ill, we;
    logic [4:0] op;
    logic [31:0] a, b;
    logic [3:0] wa;
    logic [31:0] wd;
    logic [3:0] fl;
  } vec_t;
  vec_t v [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("ready_wait", instr_ready, 1);
  endtask

  task automatic run_vec(input vec_t t);
    wait_ready();
    instr = t.ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = $urandom;
    chk("rd_raddr_a", rf_raddr_a, t.ins[19:16]);
    chk("rd_raddr_b", rf_raddr_b, t.ins[3:0]);
    chk("rd_retired", retired, t.skip);
    chk("rd_illegal", illegal, t.ill);
    chk("rd_ready", instr_ready, 0);
    chk("rd_alu_en", alu_out_en, 0);
    if (t.skip || t.ill) begin
      tick();
      chk("skip_ready", instr_ready, 1);
      chk("skip_pulses", {retired, illegal, rf_we, alu_out_en}, 0);
    end else begin
      tick();
      chk("ex_alu_en", alu_out_en, 1);
      chk("ex_alu_op", alu_op, t.op);
      chk("ex_alu_a", alu_a, t.a);
      chk("ex_alu_b", alu_b, t.b);
      chk("ex_we", rf_we, 0);
      tick();
      chk("wb_we", rf_we, t.we);
      chk("wb_waddr", rf_waddr, t.we ? t.wa : 4'd0);
      chk("wb_wdata", rf_wdata, t.we ? t.wd : 32'd0);
      chk("wb_retired", retired, 1);
      chk("wb_alu_en", alu_out_en, 0);
      tick();
      chk("post_ready", instr_ready, 1);
      chk("post_retired", retired, 0);
    end
    chk("flags", flags, t.fl);
  endtask

  initial begin
    v[0] = '{32'hE2912003, 0, 0, 1, 5'h04, 32'd5, 32'd3, 4'd2, 32'd8, 4'h0};
    v[1] = '{32'hE1510001, 0, 0, 0, 5'h0A, 32'd5, 32'd5, 4'd0, 32'd0, 4'h6};
    v[2] = '{32'h12813001, 1, 0, 0, 5'h00, 32'd0, 32'd0, 4'd0, 32'd0, 4'h6};
    v[3] = '{32'hE3A044FF, 0, 0, 1, 5'h10, 32'd0, 32'hFF000000, 4'd4, 32'hFF000000, 4'h6};
    v[4] = '{32'hE0817002, 0, 0, 1, 5'h04, 32'd5, 32'd8, 4'd7, 32'd13, 4'h6};
    v[5] = '{32'hE2515006, 0, 0, 1, 5'h02, 32'd5, 32'd6, 4'd5, 32'hFFFFFFFF, 4'h8};
    v[6] = '{32'h42816001, 0, 0, 1, 5'h04, 32'd5, 32'd1, 4'd6, 32'd6, 4'h8};
    v[7] = '{32'hA2816001, 1, 0, 0, 5'h00, 32'd0, 32'd0, 4'd0, 32'd0, 4'h8};
    v[8] = '{32'hEA000000, 0, 1, 0, 5'h00, 32'd0, 32'd0, 4'd0, 32'd0, 4'h8};
    v[9] = '{32'hE0817012, 0, 1, 0, 5'h00, 32'd0, 32'd0, 4'd0, 32'd0, 4'h8};
    repeat (3) tick();
    chk("rst_flags", flags, 0);
    chk("rst_pulses", {rf_we, alu_out_en, retired, illegal, alu_s}, 0);
    chk("rst_addr", {rf_raddr_a, rf_raddr_b, rf_waddr}, 0);
    chk("rst_data", rf_wdata | alu_a | alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", instr_ready, 1);
    for (int i = 0; i < 10; i++) run_vec(v[i]);
    chk("rf_r7", rf[7], 32'd13);

    wait_ready();
    instr = 32'hEA000000;
    instr_valid = 1'b1;
    tick();
    chk("b2b_illegal", illegal, 1);
    chk("b2b_retired", retired, 0);
    instr = 32'hE2912003;
    tick();
    chk("b2b_illegal_once", illegal, 0);
    chk("b2b_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_accepted", {instr_ready, rf_raddr_a}, {1'b0, 4'd1});
    repeat (3) tick();
    chk("b2b_flags", flags, 4'h0);

    run_vec(v[1]);
    we_seen = 1'b0;
    instr = 32'hE2919003;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("abort_exec_en", alu_out_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_alu_en", alu_out_en, 0);
    chk("abort_flags", flags, 0);
    chk("abort_ready", instr_ready, 1);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_ready_rel", instr_ready, 1);
    chk("abort_no_we", we_seen, 0);
    chk("abort_rf9", rf[9], 0);
    chk("abort_flags_rel", flags, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arm_dp_sequencer.md
Name: arm_dp_sequencer

Overview:
Multi-cycle initiator for the ARM data-processing ALU. It accepts one 32-bit instruction over a valid/ready handshake and decodes the data-processing format. It reads Rn/Rm from the register file, evaluates the condition field against its own NZCV status register, and drives the ALU operands, opcode and output enable. It then captures the ALU result and flags, and writes Rd back. It sits between instruction fetch and the register file/ALU pair.

Parameters:
DATA_W, 32, operand/result width
RADDR_W, 4, register file address width (16 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept; high only in IDLE
instr  in  32  instruction word
rf_raddr_a  out  RADDR_W  Rn address
rf_raddr_b  out  RADDR_W  Rm address
rf_rdata_a  in  DATA_W  Rn data, valid one cycle after address
rf_rdata_b  in  DATA_W  Rm data, valid one cycle after address
rf_we  out  1  register write strobe
rf_waddr  out  RADDR_W  Rd
rf_wdata  out  DATA_W  write data
alu_a  out  DATA_W  ALU operand A (Rn)
alu_b  out  DATA_W  ALU operand B (shifter operand)
alu_op  out  5  ALU opcode
alu_s  out  1  S bit to ALU
alu_out_en  out  1  ALU output enable; ALU result is high-Z otherwise
alu_flags_in  out  4  current NZCV to ALU (carry for ADC/SBC/RSC)
alu_result  in  DATA_W  ALU result
alu_flags  in  4  ALU NZCV: N=3, Z=2, C=1, V=0
flags  out  4  architectural NZCV
retired  out  1  one-cycle pulse per completed or skipped instruction
illegal  out  1  one-cycle pulse on a non-data-processing instruction

Behaviour:
- Reset state: IDLE. flags=0000; rf_we, alu_out_en, retired, illegal, alu_s = 0; address and data outputs = 0. instr_ready=1 after reset release. Reset in any state aborts the instruction with no write and no flag update.
- Handshake: the instruction is latched on the edge where instr_valid && instr_ready. instr_ready=0 in every state except IDLE. instr may change freely while instr_ready=0.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. Accept edge T.
- READ (T+1): drive rf_raddr_a=instr[19:16] and rf_raddr_b=instr[3:0]. Evaluate the condition against flags.
  - Condition fails: go to IDLE and pulse retired.
  - instr[27:26]!=00, or instr[25]=0 with instr[4]=1: go to IDLE and pulse illegal; retired stays 0.
- EXEC (T+2): alu_a=rf_rdata_a; alu_out_en=1; alu_flags_in=flags.
  - alu_b: if instr[25]=1, instr[7:0] rotated right by 2*instr[11:8]; otherwise rf_rdata_b. The shift field instr[11:5] is ignored.
  - Capture alu_result and alu_flags at the end of the cycle.
- Opcode map: alu_op={0,instr[24:21]} except MOV (1101) -> 10000, which bypasses B.
- Test ops TST/TEQ/CMP/CMN (10xx) force S=1 and suppress writeback.
- WB (T+3): rf_we=1, rf_waddr=instr[15:12], rf_wdata=captured result. Test ops keep rf_we=0.
  - If S: flags <= captured alu_flags, all four bits taken from the ALU.
  - retired pulses. The next state is IDLE, so instr_ready=1 at T+4.
- Throughput: one instruction per 4 cycles; no overlap.
- Condition codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- Outputs unused in a state hold 0, except rf_raddr_*, which hold their last value.

Decomposition:
- Package arm_dp_pkg holds:
  - state enum: IDLE, READ, EXEC, WB
  - 4-bit ARM opcode constants and 5-bit ALU opcode constants, including ALU_BYPASS_B=10000
  - condition-code constants
  - NZCV bit index constants
  - a rotate-immediate function
- Sub-module arm_cond_check: combinational, inputs cond[3:0] and nzcv[3:0], output pass.

Test Plan:
- Reset, r1=5, ADDS r2,r1,#3 (E2912003) -> T+2 alu_op=00100, alu_b=3; T+3 rf_we=1, waddr=2, wdata=8; flags=0000; retired at T+3.
- r1=5, CMP r1,r1 (E1510001) -> alu_op=01010, rf_we stays 0, flags=0110 (Z,C).
- After CMP, ADDNE r3,r1,#1 (12813001) -> skipped in READ, no ALU enable, no rf_we, retired pulse at T+1, flags stay 0110, instr_ready=1 at T+2.
- MOV r4,#0xFF000000 (E3A044FF) -> alu_op=10000, alu_b=FF000000, wdata=FF000000, waddr=4, flags unchanged (S=0).
- Branch 0xEA000000 -> illegal=1 at T+1 for exactly one cycle, retired=0, no rf_we; a back-to-back valid instruction is accepted at T+2.
- rst_n low mid-EXEC of ADDS -> rf_we never asserted, flags=0000, alu_out_en=0 immediately, instr_ready=1 on the first edge after release.
